ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter. Sends one command byte to the keyboard, e.g. 0xED (set LEDs), 0xF4 (enable) or 0xFF (reset).
- It is the opposite direction of the scan-code receive/decode path.
- It drives the PS/2 clock and data lines through open-drain enables. The top level builds the tristates.
- tx_idle gates the receive path so received frames do not collide with transmission.

---
 rtl/ps2_pkg.sv | 26 ++
 rtl/ps2_host_tx_if.sv | 24 ++
 rtl/ps2_edge_filter.sv | 60 ++++++
 rtl/ps2_host_tx.sv | 161 ++++++++++++++++
 tb/tb_ps2_host_tx.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmit FSM encoding, command bytes, parity helper.
package ps2_pkg;

    typedef enum logic [3:0] {
        IDLE,
        RTS,
        START,
        DATA,
        STOP,
        ACK,
        WAIT_REL,
        DONE,
        ERR
    } ps2_state_e;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] ACK_BYTE     = 8'hFA;

    // Odd parity bit for a PS/2 data byte: set when the byte has an even number of ones.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~(^b);
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Host-side command bus plus the open-drain PS/2 line controls of the transmitter.
interface ps2_host_tx_if;
    logic       wr_ps2;
    logic [7:0] din;
    logic       ps2c_in;
    logic       ps2d_in;
    logic       ps2c_oe;
    logic       ps2d_oe;
    logic       tx_idle;
    logic       tx_done_tick;
    logic       tx_err_tick;

    // Driver side: issues commands and supplies the raw line levels.
    modport master (
        output wr_ps2, din, ps2c_in, ps2d_in,
        input  ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, tx_err_tick
    );

    // Transmitter side.
    modport slave (
        input  wr_ps2, din, ps2c_in, ps2d_in,
        output ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, tx_err_tick
    );
endinterface

// File: rtl/ps2_edge_filter.sv
// Synchronizes the raw PS/2 lines, deglitches the clock line and flags its falling edges.
module ps2_edge_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2c_i,
    input  logic ps2d_i,
    output logic ps2c_sync_o,
    output logic ps2d_sync_o,
    output logic fall_tick_o
);

    localparam int unsigned   CNT_W    = $clog2(FILTER_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [1:0]       c_sync_q, d_sync_q;
    logic             filt_q, filt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fall_q, fall_d;

    // Glitch filter: count consecutive synced samples that disagree with the filtered level.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        filt_d = filt_q;
        cnt_d  = '0;
        fall_d = 1'b0;
        if (c_sync_q[1] != filt_q) begin
            if (cnt_q == CNT_LAST) begin
                filt_d = c_sync_q[1];
                fall_d = ~c_sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchronizer and filter state; lines reset to their idle (high) level.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values, making the 2-FF chain a real chain.
        if (reset) begin
            c_sync_q <= 2'b11;
            d_sync_q <= 2'b11;
            filt_q   <= 1'b1;
            cnt_q    <= '0;
            fall_q   <= 1'b0;
        end else begin
            c_sync_q <= {c_sync_q[0], ps2c_i};
            d_sync_q <= {d_sync_q[0], ps2d_i};
            filt_q   <= filt_d;
            cnt_q    <= cnt_d;
            fall_q   <= fall_d;
        end
    end

    assign ps2c_sync_o = c_sync_q[1];
    assign ps2d_sync_o = d_sync_q[1];
    assign fall_tick_o = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 11-bit frame, device ACK, timeout.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic         clk,
    input  logic         reset,
    ps2_host_tx_if.slave bus
);

    localparam int unsigned      INH_W      = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned      TMO_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST   = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [INH_W-1:0] INH_PENULT = INH_W'(INHIBIT_CYCLES - 2);
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);

    ps2_state_e       state_q, state_d;
    logic [8:0]       shreg_q, shreg_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [INH_W-1:0] inh_q, inh_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             c_oe_q, c_oe_d;
    logic             d_oe_q, d_oe_d;

    logic ps2c_sync;
    logic ps2d_sync;
    logic fall_tick;
    logic waiting;

    ps2_edge_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_edge_filter (
        .clk         (clk),
        .reset       (reset),
        .ps2c_i      (bus.ps2c_in),
        .ps2d_i      (bus.ps2d_in),
        .ps2c_sync_o (ps2c_sync),
        .ps2d_sync_o (ps2d_sync),
        .fall_tick_o (fall_tick)
    );

    // States in which progress depends on the device clocking.
    assign waiting = state_q inside {START, DATA, STOP, ACK, WAIT_REL};

    // Next state, datapath and the next value of the registered line enables.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        inh_d     = '0;
        tmo_d     = '0;
        c_oe_d    = 1'b0;
        d_oe_d    = 1'b0;

        if (waiting && !fall_tick) begin
            tmo_d = tmo_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.wr_ps2) begin
                    state_d = RTS;
                    shreg_d = {odd_parity(bus.din), bus.din};
                    c_oe_d  = 1'b1;
                end
            end
            RTS: begin
                c_oe_d = 1'b1;
                inh_d  = inh_q + 1'b1;
                if (inh_q == INH_LAST) begin
                    state_d = START;
                    c_oe_d  = 1'b0;
                    d_oe_d  = 1'b1;
                    inh_d   = '0;
                end else if (inh_q == INH_PENULT) begin
                    // Start bit goes out together with the last inhibit cycle.
                    d_oe_d = 1'b1;
                end
            end
            START: begin
                d_oe_d = 1'b1;
                if (fall_tick) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    d_oe_d    = ~shreg_q[0];
                end
            end
            DATA: begin
                d_oe_d = ~shreg_q[0];
                if (fall_tick) begin
                    if (bit_cnt_q == 4'd8) begin
                        // Parity has been clocked; releasing data presents the stop bit.
                        state_d = STOP;
                        d_oe_d  = 1'b0;
                    end else begin
                        shreg_d   = {1'b0, shreg_q[8:1]};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        d_oe_d    = ~shreg_q[1];
                    end
                end
            end
            STOP: begin
                if (fall_tick) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                if (fall_tick) begin
                    state_d = ps2d_sync ? ERR : WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (ps2c_sync && ps2d_sync) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A silent device aborts the frame with both lines released.
        if (waiting && !fall_tick && (tmo_q == TMO_LAST)) begin
            state_d = ERR;
            c_oe_d  = 1'b0;
            d_oe_d  = 1'b0;
        end
    end

    // State register; reset abandons any frame and releases both lines.
    always_ff @(posedge clk) begin
        // NOTE: the shift register and counters are cleared as well, so an abandoned frame leaves no stale bits behind.
        if (reset) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            inh_q     <= '0;
            tmo_q     <= '0;
            c_oe_q    <= 1'b0;
            d_oe_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            inh_q     <= inh_d;
            tmo_q     <= tmo_d;
            c_oe_q    <= c_oe_d;
            d_oe_q    <= d_oe_d;
        end
    end

    assign bus.ps2c_oe      = c_oe_q;
    assign bus.ps2d_oe      = d_oe_q;
    assign bus.tx_idle      = (state_q == IDLE);
    assign bus.tx_done_tick = (state_q == DONE);
    assign bus.tx_err_tick  = (state_q == ERR);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames and checks bits against a scoreboard.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH  = 20;
    localparam int FL   = 4;
    localparam int TMO  = 2000;
    localparam int HALF = 100;

    logic clk;
    logic reset;
    logic dev_c;
    logic dev_d;
    logic glitch;
    int   cyc;
    int   done_cnt;
    int   err_cnt;
    int   n_checks;
    int   n_errors;
    logic exp_q[$];

    ps2_host_tx_if bus_if ();

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .FILTER_LEN     (FL),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    // Open-drain lines: low if either side pulls them down.
    assign bus_if.ps2c_in = dev_c & ~glitch & ~bus_if.ps2c_oe;
    assign bus_if.ps2d_in = dev_d & ~bus_if.ps2d_oe;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (bus_if.tx_done_tick === 1'b1) done_cnt <= done_cnt + 1;
        if (bus_if.tx_err_tick === 1'b1)  err_cnt  <= err_cnt + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Issue a command, push its expected line bits, and measure the request-to-send phase.
    task automatic send_byte(input logic [7:0] b, input bit busy_wr, output int t_start);
        int ones;
        int c_cnt;
        int d_first;
        ones = 0;
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(b[k]);
            ones += int'(b[k]);
        end
        exp_q.push_back((ones % 2 == 0) ? 1'b1 : 1'b0);
        exp_q.push_back(1'b1);

        @(negedge clk);
        bus_if.wr_ps2 = 1'b1;
        bus_if.din    = b;
        @(negedge clk);
        bus_if.wr_ps2 = 1'b0;
        check("wr_to_ps2c_oe", int'(bus_if.ps2c_oe), 1);

        c_cnt   = 0;
        d_first = 0;
        while (bus_if.ps2c_oe === 1'b1 && c_cnt < 10 * INH) begin
            c_cnt++;
            if (bus_if.ps2d_oe === 1'b1 && d_first == 0) d_first = c_cnt;
            if (busy_wr && c_cnt == 5) begin
                check("busy_tx_idle", int'(bus_if.tx_idle), 0);
                bus_if.wr_ps2 = 1'b1;
                bus_if.din    = 8'h00;
            end else begin
                bus_if.wr_ps2 = 1'b0;
            end
            @(negedge clk);
        end
        bus_if.wr_ps2 = 1'b0;
        check("rts_ps2c_len", c_cnt, INH);
        check("rts_ps2d_first", d_first, INH);
        check("start_ps2d_oe", int'(bus_if.ps2d_oe), 1);
        t_start = cyc;
    endtask

    // Device model: 12 clock pulses, samples data late in each low phase, ACK/NACK on the last.
    task automatic dev_clock(input bit nack, input int abort_at, input bit glitchy);
        logic exp_bit;
        int   d0;
        int   e0;
        repeat (50) @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            if (i == abort_at) begin
                check("busy_before_rst", int'(bus_if.tx_idle), 0);
                d0 = done_cnt;
                e0 = err_cnt;
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                check("rst_ps2c_oe", int'(bus_if.ps2c_oe), 0);
                check("rst_ps2d_oe", int'(bus_if.ps2d_oe), 0);
                check("rst_tx_idle", int'(bus_if.tx_idle), 1);
                repeat (20) @(negedge clk);
                check("rst_no_done", done_cnt - d0, 0);
                check("rst_no_err", err_cnt - e0, 0);
                exp_q.delete();
                return;
            end
            dev_c = 1'b0;
            repeat (HALF) @(negedge clk);
            if (i < 10 && exp_q.size() > 0) begin
                exp_bit = exp_q.pop_front();
                check($sformatf("frame_bit%0d", i), int'(bus_if.ps2d_in), int'(exp_bit));
            end
            if (i == 10 && !nack) dev_d = 1'b0;
            if (i == 11) dev_d = 1'b1;
            dev_c = 1'b1;
            if (glitchy && (i == 2 || i == 5)) begin
                repeat (30) @(negedge clk);
                glitch = 1'b1;
                repeat (2) @(negedge clk);
                glitch = 1'b0;
                repeat (HALF - 32) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
        end
    endtask

    task automatic run_frame(input logic [7:0] b, input bit nack, input int abort_at,
                             input bit glitchy, input bit busy_wr, input string name);
        int d0;
        int e0;
        int t;
        int n;
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(b, busy_wr, t);
        dev_clock(nack, abort_at, glitchy);
        if (abort_at < 0) begin
            n = 0;
            while (done_cnt == d0 && err_cnt == e0 && n < 2000) begin
                @(negedge clk);
                n++;
            end
            repeat (3) @(negedge clk);
            check({name, "_done_ticks"}, done_cnt - d0, nack ? 0 : 1);
            check({name, "_err_ticks"}, err_cnt - e0, nack ? 1 : 0);
            check({name, "_tx_idle"}, int'(bus_if.tx_idle), 1);
            check({name, "_ps2c_oe"}, int'(bus_if.ps2c_oe), 0);
            check({name, "_ps2d_oe"}, int'(bus_if.ps2d_oe), 0);
        end
    endtask

    initial begin
        int d0;
        int e0;
        int t0;
        int n;
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        done_cnt = 0;
        err_cnt  = 0;
        dev_c    = 1'b1;
        dev_d    = 1'b1;
        glitch   = 1'b0;

        // Reset held together with a write strobe: reset must win.
        reset         = 1'b1;
        bus_if.wr_ps2 = 1'b1;
        bus_if.din    = CMD_RESET;
        repeat (3) @(negedge clk);
        check("reset_tx_idle", int'(bus_if.tx_idle), 1);
        check("reset_ps2c_oe", int'(bus_if.ps2c_oe), 0);
        check("reset_ps2d_oe", int'(bus_if.ps2d_oe), 0);
        check("reset_done_tick", int'(bus_if.tx_done_tick), 0);
        check("reset_err_tick", int'(bus_if.tx_err_tick), 0);
        reset         = 1'b0;
        bus_if.wr_ps2 = 1'b0;
        repeat (20) @(negedge clk);

        run_frame(CMD_SET_LEDS, 1'b0, -1, 1'b0, 1'b0, "ed");
        run_frame(CMD_ENABLE,   1'b0, -1, 1'b0, 1'b0, "f4");
        run_frame(8'h00,        1'b0, -1, 1'b0, 1'b0, "zero");
        run_frame(CMD_ENABLE,   1'b1, -1, 1'b0, 1'b0, "nack");

        // Silent device: error exactly TMO cycles after START is entered.
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(CMD_RESET, 1'b0, t0);
        exp_q.delete();
        n = 0;
        while (bus_if.tx_err_tick !== 1'b1 && n < TMO + 500) begin
            @(negedge clk);
            n++;
        end
        check("timeout_cycles", cyc - t0, TMO);
        check("timeout_ps2c_oe", int'(bus_if.ps2c_oe), 0);
        check("timeout_ps2d_oe", int'(bus_if.ps2d_oe), 0);
        repeat (3) @(negedge clk);
        check("timeout_tx_idle", int'(bus_if.tx_idle), 1);
        check("timeout_done_ticks", done_cnt - d0, 0);
        check("timeout_err_ticks", err_cnt - e0, 1);

        // Reset after four data bits, then a normal frame.
        run_frame(CMD_SET_LEDS, 1'b0, 4, 1'b0, 1'b0, "abort");
        repeat (20) @(negedge clk);
        run_frame(CMD_RESET, 1'b0, -1, 1'b0, 1'b0, "ff_after_rst");

        // Clock glitches during DATA and a write strobe while busy.
        run_frame(8'hA5, 1'b0, -1, 1'b1, 1'b1, "glitch_busy");

        repeat (10) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
